// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between NUM_REQ byte-stream
// requesters. Round-robin grant per packet, the lock is held until the byte
// flagged req_last has gone out, bytes are paced on tx_done plus GAP_TICKS
// idle cycles, and a stalled owner loses the lock after HOLD_TIMEOUT cycles.
//
// Handshake: requester i raises req_valid[i] with req_data/req_last and holds
// all three stable until it sees req_ready[i] high for one cycle; the byte is
// accepted at the clock edge that ends that cycle. req_ready is only ever high
// in SEND, for the current owner only, together with tx_start.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_TICKS    = 0,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic [2:0]                 dbg_state_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int HW  = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [7:0]     GAP_LAST  = (GAP_TICKS > 0) ? 8'(GAP_TICKS - 1) : 8'd0;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           locked_q, locked_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           last_q, last_d;
  logic [7:0]     gap_q, gap_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           rr_found;
  logic [IDW-1:0] rr_winner;
  int             best_dist;
  int             cur_dist;

  logic [IDW-1:0] sel_id;
  logic [7:0]     sel_data;
  logic           sel_last;
  logic           own_valid;
  logic           post_gap;

  // Round-robin search: nearest valid requester after grant_q, wrapping.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = grant_q;
    best_dist = NUM_REQ;
    cur_dist  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_dist = i - int'(grant_q) - 1;
      if (cur_dist < 0) cur_dist = cur_dist + NUM_REQ;
      if (req_valid[i] && (cur_dist < best_dist)) begin
        rr_found  = 1'b1;
        best_dist = cur_dist;
        rr_winner = IDW'(i);
      end
    end
  end

  // Pick the byte that will be presented in SEND: the new winner when leaving
  // IDLE, otherwise the current owner. Also the owner's own valid for HOLD.
  always_comb begin
    sel_id    = (state_q == S_IDLE) ? rr_winner : grant_q;
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    own_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == sel_id) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
      if (IDW'(i) == grant_q) own_valid = req_valid[i];
    end
  end

  // Next-state logic; tx_data and last flag are loaded on entry to SEND so
  // the byte is already on tx_data while tx_start is high.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    locked_d  = locked_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    gap_d     = gap_q;
    hold_d    = hold_q;
    post_gap  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          grant_d  = rr_winner;
          locked_d = 1'b1;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          if (GAP_TICKS > 0) begin
            state_d = S_GAP;
            gap_d   = 8'd0;
          end else begin
            post_gap = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) post_gap = 1'b1;
        else                   gap_d    = gap_q + 8'd1;
      end
      S_HOLD: begin
        if (own_valid) begin
          state_d = S_SEND;
        end else if (hold_q == HOLD_LAST) begin
          locked_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // End of the inter-byte gap: release on the last byte, chain straight into
    // the owner's next byte if it is already waiting, otherwise start holding.
    if (post_gap) begin
      gap_d = 8'd0;
      if (last_q) begin
        locked_d = 1'b0;
        state_d  = S_IDLE;
      end else if (own_valid) begin
        state_d = S_SEND;
      end else begin
        state_d = S_HOLD;
        hold_d  = '0;
      end
    end

    if ((state_q == S_HOLD) && (state_d != S_HOLD)) hold_d = '0;

    if (state_d == S_SEND) begin
      tx_data_d = sel_data;
      last_d    = sel_last;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= LAST_ID;
      locked_q  <= 1'b0;
      tx_data_q <= 8'h00;
      last_q    <= 1'b0;
      gap_q     <= 8'd0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      locked_q  <= locked_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      hold_q    <= hold_d;
    end
  end

  // SEND is exactly one cycle, so tx_start and the owner's req_ready pulse together.
  always_comb begin
    tx_start  = (state_q == S_SEND);
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_q == S_SEND) && (IDW'(i) == grant_q)) req_ready[i] = 1'b1;
    end
  end

  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign locked      = locked_q;
  assign dbg_state_o = state_q;

endmodule
